pe_array_os: RTL and testbench
==============================

Name: pe_array_os

Overview:
- Parameterised output-stationary systolic array of ROW_len x COL_len multiply-accumulate PEs.
- Operands enter the array skewed:
  - one A element per row on the left edge, flowing right;
  - one B element per column on the top edge, flowing down.
- Each PE keeps its own accumulator.
- Results are unloaded one row per cycle through a column shift chain to c_bus.
- Used as the fixed-size tile engine inside the matrix-multiply AXIS wrapper. The wrapper does the tiling, the skewing and the result write-back.

Parameters:
- ROW_len, 8, number of PE rows (A-input lanes).
- COL_len, 8, number of PE columns (B-input lanes and c_bus lanes).
- DW, 8, signed operand width.
- ACCW, 16, signed accumulator and output width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- compute_en  in  1  advances the operand pipeline and enables MAC.
- read_en_in  in  1  unload mode: shift accumulators down one row per cycle.
- a_bus  in  ROW_len*DW  lane r = a_bus[(r+1)*DW-1 -: DW], signed, enters PE[r][0].
- b_bus  in  COL_len*DW  lane c = b_bus[(c+1)*DW-1 -: DW], signed, enters PE[0][c].
- c_bus  out  COL_len*ACCW  lane c = c_bus[(c+1)*ACCW-1 -: ACCW], registered.

Behaviour:
- Reset is asynchronous. It clears every a/b pipeline register, every accumulator and c_bus to 0.
- PE[r][c] state: a_reg, b_reg, acc. All updates occur on the rising edge.
- Priority per cycle is read_en_in, then compute_en, then hold.
- When read_en_in=1:
  - c_bus lane c <= acc[ROW_len-1][c];
  - acc[r][c] <= acc[r-1][c] for r>0;
  - acc[0][c] <= 0;
  - no MAC occurs; a_reg and b_reg are cleared to 0.
- When read_en_in=0 and compute_en=1:
  - a_reg[r][c] <= (c==0 ? a lane r : a_reg[r][c-1]);
  - b_reg[r][c] <= (r==0 ? b lane c : b_reg[r-1][c]);
  - acc[r][c] <= acc + sext(a_in*b_in). Here a_in and b_in are the same values being latched this cycle, so the product uses the operands arriving at the PE.
- When both are 0: all state holds; c_bus holds.
- Arithmetic:
  - the DW x DW signed product is 2*DW bits;
  - it is sign-extended or truncated to ACCW;
  - accumulation wraps modulo 2^ACCW with no saturation.
- Accumulators persist while compute_en stays high, including across consecutive K-tiles. Clearing happens only through reset or the read shift.
- Compute latency: with a skewed feed (row r delayed r cycles, column c delayed c cycles, K terms), PE[r][c] receives its last term K+r+c cycles after the first input.
- Unload: assert read_en_in for ROW_len+1 cycles.
  - c_bus is registered, so it shows row ROW_len-1 one cycle after the first read_en_in cycle.
  - It then shows rows ROW_len-2 down to 0 on the following cycles.
  - After ROW_len shifts, all accumulators are 0 and the array is ready for the next output tile.
- Unused rows and columns (zero-fed) accumulate 0 and unload 0.
- Reset asserted mid-compute or mid-unload discards all results immediately.

Decomposition:
- No shared package is required; the widths are module parameters.
- Use one natural sub-module, pe_os_cell. It holds a_reg, b_reg and acc, with ports a_in, b_in, acc_in (from the cell above), compute_en, read_en, a_out, b_out and acc_out.
- Instantiate it in a 2-D generate loop.

Test Plan:
- Reset with all inputs at arbitrary values -> c_bus=0; unloading 9 cycles yields all zeros.
- 2x2 matrix test with ROW_len=COL_len=2:
  - stimulus: A=[[1,2],[3,4]], B=[[5,6],[7,8]] fed skewed for 4 cycles, then zeros for 2 cycles;
  - then read_en_in for 3 cycles;
  - required response: c_bus sequence is row1=(43,50), then row0=(19,22).
- Signed operands -> A=-128 x B=-128 at one PE, twice: acc = 32768 wraps to 16'h8000 (ACCW=16).
- K-tile continuation:
  - stimulus: feed the K=0..3 half, keep compute_en=1, then feed the K=4..7 half;
  - required response: unloaded values equal the full 8-term dot products.
- Back-to-back tiles: after unload, a new 8x8 identity x B product -> output equals B exactly, with no residue from the previous tile.
- compute_en=0 mid-stream for 3 cycles with inputs held -> results are identical to the uninterrupted run once compute_en resumes.

Source files
------------

// File: rtl/pe_os_cell.sv
// pe_os_cell: one output-stationary MAC PE that forwards operands right/down and shifts its accumulator down on unload
module pe_os_cell #(
  parameter int DW   = 8,
  parameter int ACCW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   compute_en,
  input  logic                   read_en,
  input  logic signed [DW-1:0]   a_in,
  input  logic signed [DW-1:0]   b_in,
  input  logic signed [ACCW-1:0] acc_in,
  output logic signed [DW-1:0]   a_out,
  output logic signed [DW-1:0]   b_out,
  output logic signed [ACCW-1:0] acc_out
);
  logic signed [2*DW-1:0] prod;
  assign prod = a_in * b_in;
  // unload shift has priority over MAC; the product uses the operands being latched this cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_out   <= '0;
      b_out   <= '0;
      acc_out <= '0;
    end else if (read_en) begin
      a_out   <= '0;
      b_out   <= '0;
      acc_out <= acc_in;
    end else if (compute_en) begin
      a_out   <= a_in;
      b_out   <= b_in;
      acc_out <= acc_out + ACCW'(prod);
    end
endmodule

// File: rtl/pe_array_os.sv
// pe_array_os: output-stationary systolic MAC array with row-by-row result unload onto c_bus
module pe_array_os #(
  parameter int ROW_len = 8,
  parameter int COL_len = 8,
  parameter int DW      = 8,
  parameter int ACCW    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      compute_en,
  input  logic                      read_en_in,
  input  logic [ROW_len*DW-1:0]     a_bus,
  input  logic [COL_len*DW-1:0]     b_bus,
  output logic [COL_len*ACCW-1:0]   c_bus
);
  logic signed [DW-1:0]   a_o   [ROW_len][COL_len];
  logic signed [DW-1:0]   b_o   [ROW_len][COL_len];
  logic signed [ACCW-1:0] acc_o [ROW_len][COL_len];
  for (genvar r = 0; r < ROW_len; r++) begin : g_row
    for (genvar c = 0; c < COL_len; c++) begin : g_col
      logic signed [DW-1:0]   a_i;
      logic signed [DW-1:0]   b_i;
      logic signed [ACCW-1:0] acc_i;
      if (c == 0) begin : g_a_edge
        assign a_i = a_bus[r*DW +: DW];
      end else begin : g_a_chain
        assign a_i = a_o[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_i   = b_bus[c*DW +: DW];
        assign acc_i = '0;
      end else begin : g_b_chain
        assign b_i   = b_o[r-1][c];
        assign acc_i = acc_o[r-1][c];
      end
      pe_os_cell #(.DW(DW), .ACCW(ACCW)) u_cell (
        .clk        (clk),
        .rst_n      (rst_n),
        .compute_en (compute_en),
        .read_en    (read_en_in),
        .a_in       (a_i),
        .b_in       (b_i),
        .acc_in     (acc_i),
        .a_out      (a_o[r][c]),
        .b_out      (b_o[r][c]),
        .acc_out    (acc_o[r][c])
      );
    end
  end
  // capture the bottom row while unloading so results appear one row per cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      c_bus <= '0;
    else if (read_en_in)
      for (int i = 0; i < COL_len; i++)
        c_bus[i*ACCW +: ACCW] <= acc_o[ROW_len-1][i];
endmodule

// File: tb/tb_pe_array_os.sv
// tb_pe_array_os: scoreboard bench feeding skewed matrices and checking unloaded rows
module tb_pe_array_os;
  localparam int R = 8, C = 8, DW = 8, ACCW = 16;
  logic clk = 0, rst_n = 0, compute_en = 0, read_en_in = 0;
  logic [R*DW-1:0]   a_bus = '0;
  logic [C*DW-1:0]   b_bus = '0;
  logic [C*ACCW-1:0] c_bus;
  pe_array_os #(.ROW_len(R), .COL_len(C), .DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .compute_en(compute_en), .read_en_in(read_en_in),
    .a_bus(a_bus), .b_bus(b_bus), .c_bus(c_bus)
  );
  always #5 clk = ~clk;
  int am [R][8];
  int bm [8][C];
  int ex [R][C];
  logic [C*ACCW-1:0] sb [$];
  logic [C*ACCW-1:0] er;
  logic read_q;
  int n_chk = 0, n_fail = 0;
  string cur = "reset";
  always @(posedge clk or negedge rst_n)
    if (!rst_n) read_q <= 1'b0;
    else read_q <= read_en_in;
  always @(negedge clk)
    if (read_q) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s unload: c_bus=%h but no row expected", cur, c_bus);
      end else begin
        er = sb.pop_front();
        if (c_bus !== er) begin
          n_fail++;
          $display("FAIL %s unload: c_bus=%h required %h", cur, c_bus, er);
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_mats();
    for (int r = 0; r < R; r++) for (int k = 0; k < 8; k++) am[r][k] = 0;
    for (int k = 0; k < 8; k++) for (int c = 0; c < C; c++) bm[k][c] = 0;
  endtask
  task automatic fill_mats();
    for (int r = 0; r < R; r++) for (int k = 0; k < 8; k++) am[r][k] = ((r*8+k)*37) % 256 - 128;
    for (int k = 0; k < 8; k++) for (int c = 0; c < C; c++) bm[k][c] = ((k*8+c)*53+11) % 256 - 128;
  endtask
  task automatic feed(input int k0, input int k, input int pause_at, input bit mdl);
    for (int t = 0; t < k + R + C - 1; t++) begin
      for (int r = 0; r < R; r++)
        a_bus[r*DW +: DW] = (t-r >= 0 && t-r < k) ? 8'(am[r][k0+t-r]) : 8'd0;
      for (int c = 0; c < C; c++)
        b_bus[c*DW +: DW] = (t-c >= 0 && t-c < k) ? 8'(bm[k0+t-c][c]) : 8'd0;
      if (t == pause_at) begin
        compute_en = 0;
        repeat (3) tick();
      end
      compute_en = 1;
      tick();
    end
    compute_en = 0;
    a_bus = '0;
    b_bus = '0;
    if (mdl)
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++)
        for (int kk = k0; kk < k0 + k; kk++) ex[r][c] += am[r][kk] * bm[kk][c];
  endtask
  task automatic unload();
    logic [C*ACCW-1:0] row;
    for (int r = R-1; r >= 0; r--) begin
      for (int c = 0; c < C; c++) row[c*ACCW +: ACCW] = 16'(ex[r][c]);
      sb.push_back(row);
    end
    sb.push_back('0);
    read_en_in = 1;
    repeat (R+1) tick();
    read_en_in = 0;
    tick();
    tick();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) ex[r][c] = 0;
  endtask
  task automatic chk_zero(input string nm);
    n_chk++;
    if (c_bus !== '0) begin
      n_fail++;
      $display("FAIL %s: c_bus=%h required 0", nm, c_bus);
    end
  endtask
  initial begin
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) ex[r][c] = 0;
    a_bus = {$urandom, $urandom};
    b_bus = {$urandom, $urandom};
    compute_en = 1;
    read_en_in = 1'($urandom);
    repeat (3) tick();
    chk_zero("reset_hold");
    compute_en = 0;
    read_en_in = 0;
    a_bus = '0;
    b_bus = '0;
    rst_n = 1;
    tick();
    chk_zero("reset_release");
    unload();
    cur = "mat2x2";
    clr_mats();
    am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
    bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
    feed(0, 2, -1, 0);
    ex[0][0] = 19; ex[0][1] = 22; ex[1][0] = 43; ex[1][1] = 50;
    unload();
    cur = "signed_wrap";
    clr_mats();
    am[3][0] = -128; am[3][1] = -128;
    bm[0][5] = -128; bm[1][5] = -128;
    feed(0, 2, -1, 0);
    ex[3][5] = 32'h8000;
    unload();
    cur = "ktile";
    fill_mats();
    feed(0, 4, -1, 1);
    feed(4, 4, -1, 1);
    unload();
    cur = "pause";
    feed(0, 8, 5, 1);
    unload();
    cur = "identity";
    clr_mats();
    for (int r = 0; r < R; r++) am[r][r] = 1;
    for (int k = 0; k < 8; k++) for (int c = 0; c < C; c++) bm[k][c] = (k*8+c)*3 - 90;
    feed(0, 8, -1, 0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) ex[r][c] = bm[r][c];
    unload();
    cur = "mid_reset";
    fill_mats();
    feed(0, 4, -1, 0);
    rst_n = 0;
    tick();
    chk_zero("mid_reset_cbus");
    rst_n = 1;
    tick();
    unload();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d rows left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
